// File: rtl/whack_game_ctrl_pkg.sv
// Shared types and default constants for the whack-a-mole game controller.
package whack_game_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    UP,
    HIT,
    MISS,
    OVER
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int unsigned DEF_TICK_DIV   = 2500;
  localparam int unsigned DEF_MOLE_TICKS = 200;
  localparam int unsigned DEF_SHOW_TICKS = 100;
  localparam int unsigned DEF_MAX_MISSES = 3;

endpackage

// File: rtl/whack_game_ctrl_tick_gen.sv
// Game tick divider: one-cycle tick every TICK_DIV clocks, restartable via clear.
module tick_gen
  import whack_game_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || tick) cnt <= '0;
    else                      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game FSM: mole spawning with no-repeat rule, hit/miss timing,
// saturating BCD score and miss counting.
module whack_game_ctrl
  import whack_game_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned MOLE_TICKS = DEF_MOLE_TICKS,
  parameter int unsigned SHOW_TICKS = DEF_SHOW_TICKS,
  parameter int unsigned MAX_MISSES = DEF_MAX_MISSES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [3:0] rand_signal,
  output logic [3:0] mole_position,
  output logic       mole_active,
  output logic       hit_flag,
  output logic       miss_flag,
  output bcd_t       score_ones,
  output bcd_t       score_tens,
  output logic [1:0] misses,
  output logic       game_over
);

  localparam int unsigned CMAX = (MOLE_TICKS > SHOW_TICKS) ? MOLE_TICKS : SHOW_TICKS;
  localparam int unsigned CW   = (CMAX > 0) ? $clog2(CMAX + 1) : 1;

  state_t        state, next_state;
  logic [CW-1:0] down;
  logic          tick, clear, hit;

  function automatic logic [7:0] bcd_inc(input bcd_t tens, input bcd_t ones);
    if (ones == 4'd9) begin
      if (tens == 4'd9) return {tens, ones};
      return {tens + 4'd1, 4'd0};
    end
    return {tens, ones + 4'd1};
  endfunction

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  assign hit = (state == UP) && key_valid && (key_code == mole_position);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    mole_active = 1'b0;
    hit_flag    = 1'b0;
    miss_flag   = 1'b0;
    game_over   = 1'b0;
    unique case (state)
      IDLE:  if (start) next_state = SPAWN;
      SPAWN: next_state = UP;
      UP: begin
        mole_active = 1'b1;
        // a matching key wins over a same-cycle timer expiry
        if (hit)              next_state = HIT;
        else if (down == '0)  next_state = MISS;
      end
      HIT: begin
        hit_flag = 1'b1;
        if (tick && down <= CW'(1)) next_state = SPAWN;
      end
      MISS: begin
        miss_flag = 1'b1;
        if (tick && down <= CW'(1))
          next_state = (32'(misses) == MAX_MISSES) ? OVER : SPAWN;
      end
      OVER: begin
        game_over = 1'b1;
        if (start) next_state = SPAWN;
      end
      default: next_state = IDLE;
    endcase
    clear = (next_state != state) &&
            (next_state == SPAWN || next_state == HIT || next_state == MISS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mole_position <= '0;
      score_tens    <= '0;
      score_ones    <= '0;
      misses        <= '0;
      down          <= '0;
    end else begin
      unique case (state)
        IDLE, OVER: begin
          if (start) begin
            score_tens <= '0;
            score_ones <= '0;
            misses     <= '0;
          end
        end
        SPAWN: begin
          mole_position <= (rand_signal == mole_position) ? rand_signal + 4'd1 : rand_signal;
          down          <= CW'(MOLE_TICKS);
        end
        UP: begin
          if (hit) begin
            {score_tens, score_ones} <= bcd_inc(score_tens, score_ones);
            down <= CW'(SHOW_TICKS);
          end else if (down == '0) begin
            misses <= misses + 2'd1;
            down   <= CW'(SHOW_TICKS);
          end else if (tick) begin
            down <= down - CW'(1);
          end
        end
        HIT, MISS: begin
          if (tick && down > CW'(1)) down <= down - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Scoreboard bench for whack_game_ctrl: stimulus tasks queue time-stamped output
// snapshots, a monitor compares every observed output change against the queue.
module tb_whack_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, key_valid;
  logic [3:0] key_code, rand_signal;
  logic [3:0] mole_position, score_ones, score_tens;
  logic       mole_active, hit_flag, miss_flag, game_over;
  logic [1:0] misses;

  whack_game_ctrl #(
    .TICK_DIV  (4),
    .MOLE_TICKS(3),
    .SHOW_TICKS(2),
    .MAX_MISSES(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .rand_signal  (rand_signal),
    .mole_position(mole_position),
    .mole_active  (mole_active),
    .hit_flag     (hit_flag),
    .miss_flag    (miss_flag),
    .score_ones   (score_ones),
    .score_tens   (score_tens),
    .misses       (misses),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pos;
    logic       active, hit, miss, over;
    logic [3:0] tens, ones;
    logic [1:0] mis;
  } snap_t;

  typedef struct packed {
    int    c;
    snap_t s;
  } ev_t;

  ev_t   q[$];
  snap_t cur, prev;
  int    cyc = 0;
  int    n_checks = 0, n_fail = 0;
  logic  mon_en = 1'b0;

  // reference model state
  logic [3:0] m_pos;
  int         m_score, m_misses;

  assign cur = {mole_position, mole_active, hit_flag, miss_flag, game_over,
                score_tens, score_ones, misses};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && cur != prev) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, cur);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (cur != e.s || cyc != e.c) begin
          n_fail++;
          $display("FAIL output_event got cyc=%0d pos=%0d act=%b hit=%b miss=%b over=%b score=%0d%0d mis=%0d | required cyc=%0d pos=%0d act=%b hit=%b miss=%b over=%b score=%0d%0d mis=%0d",
                   cyc, cur.pos, cur.active, cur.hit, cur.miss, cur.over, cur.tens, cur.ones, cur.mis,
                   e.c, e.s.pos, e.s.active, e.s.hit, e.s.miss, e.s.over, e.s.tens, e.s.ones, e.s.mis);
        end
      end
      prev = cur;
    end
  end

  function automatic snap_t mk(logic [3:0] p, logic a, logic h, logic m, logic o);
    snap_t s;
    s.pos    = p;
    s.active = a;
    s.hit    = h;
    s.miss   = m;
    s.over   = o;
    s.tens   = 4'(m_score / 10);
    s.ones   = 4'(m_score % 10);
    s.mis    = 2'(m_misses);
    return s;
  endfunction

  task automatic push(input int d, input snap_t s);
    ev_t e;
    e.c = cyc + d;
    e.s = s;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  function automatic logic [3:0] spawn_pos(input logic [3:0] rnd);
    return (rnd == m_pos) ? ((rnd == 4'd15) ? 4'd0 : rnd + 4'd1) : rnd;
  endfunction

  // Called from IDLE/OVER; returns in the first UP cycle.
  task automatic start_game(input logic [3:0] rnd, input bit from_over);
    rand_signal = rnd;
    start       = 1'b1;
    if (from_over) begin
      m_score  = 0;
      m_misses = 0;
      push(1, mk(m_pos, 0, 0, 0, 0));
    end
    m_pos = spawn_pos(rnd);
    push(2, mk(m_pos, 1, 0, 0, 0));
    wait_cyc(1);
    start = 1'b0;
    wait_cyc(1);
  endtask

  // Press the mole key after d UP cycles; returns in the first UP cycle of the next mole.
  task automatic hit(input int d, input logic [3:0] rnd);
    wait_cyc(d);
    key_valid   = 1'b1;
    key_code    = m_pos;
    rand_signal = rnd;
    m_score     = (m_score < 99) ? m_score + 1 : 99;
    push(1, mk(m_pos, 0, 1, 0, 0));
    push(9, mk(m_pos, 0, 0, 0, 0));
    m_pos = spawn_pos(rnd);
    push(10, mk(m_pos, 1, 0, 0, 0));
    wait_cyc(1);
    key_valid = 1'b0;
    wait_cyc(9);
  endtask

  // Called in the first UP cycle; lets the mole expire.
  task automatic timeout(input logic [3:0] rnd);
    rand_signal = rnd;
    m_misses    = m_misses + 1;
    push(12, mk(m_pos, 0, 0, 1, 0));
    if (m_misses == 3) begin
      push(20, mk(m_pos, 0, 0, 0, 1));
    end else begin
      push(20, mk(m_pos, 0, 0, 0, 0));
      m_pos = spawn_pos(rnd);
      push(21, mk(m_pos, 1, 0, 0, 0));
    end
    wait_cyc(21);
  endtask

  // Inputs that must not change anything in the current state.
  task automatic noise(input logic [3:0] code, input logic st);
    key_valid = 1'b1;
    key_code  = code;
    start     = st;
    wait_cyc(1);
    key_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic reset_mid();
    wait_cyc(2);
    rst       = 1'b1;
    start     = 1'b1;
    key_valid = 1'b1;
    key_code  = m_pos;
    m_pos     = 4'd0;
    m_score   = 0;
    m_misses  = 0;
    push(1, mk(4'd0, 0, 0, 0, 0));
    wait_cyc(1);
    rst       = 1'b0;
    start     = 1'b0;
    key_valid = 1'b0;
    wait_cyc(3);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    key_valid   = 1'b0;
    key_code    = 4'd0;
    rand_signal = 4'd0;
    m_pos       = 4'd0;
    m_score     = 0;
    m_misses    = 0;
    prev        = '1;

    wait_cyc(2);
    push(1, mk(4'd0, 0, 0, 0, 0));
    mon_en = 1'b1;
    rst    = 1'b0;
    wait_cyc(1);

    start_game(4'd5, 1'b0);
    noise(4'd7, 1'b1);
    hit(1, 4'd15);
    hit(11, 4'd15);
    timeout(4'd3);
    timeout(4'd3);
    timeout(4'd9);
    noise(m_pos, 1'b0);
    wait_cyc(3);

    start_game(4'd8, 1'b1);
    reset_mid();

    start_game(4'd2, 1'b0);
    for (int i = 0; i < 100; i++) hit(i % 7, 4'((i * 5 + 1) % 16));
    wait_cyc(4);

    while (q.size() > 0) begin
      ev_t e;
      e = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_event got=none required cyc=%0d snap=%h", e.c, e.s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
